mem_responder: RTL

Memory-side responder for the core's 16-bit single-port memory interface. It serves read and write requests from the core's fetch, read16 and write16 states out of an internal word RAM. Read data returns with a fixed 2-cycle latency, matching the core's fetch/fetch_addr/fetch_data timing. The top 16 words of the address space are a memory-mapped I/O window holding the LED register, the synchronized switches and a free-running cycle counter.

---
 rtl/mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 16-bit word RAM responder with 2-cycle read latency and a 16-word I/O window
module mem_responder #(
    parameter int                ADDR_W  = 13,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] IO_BASE = 13'h1FF0
) (
    input  logic              CLK,
    input  logic              I_RESET,
    input  logic              I_REQ,
    input  logic              I_WE,
    input  logic [ADDR_W-1:0] I_ADDR,
    input  logic [DATA_W-1:0] I_DIN,
    input  logic [3:0]        I_SW,
    output logic [DATA_W-1:0] O_DOUT,
    output logic              O_VALID,
    output logic [3:0]        O_LED
);

    localparam int          RAM_DEPTH = 1 << ADDR_W;
    localparam int          CNT_W     = 16;
    localparam logic [3:0]  OFF_LED   = 4'd0;
    localparam logic [3:0]  OFF_SW    = 4'd1;
    localparam logic [3:0]  OFF_CNT   = 4'd2;

    logic [DATA_W-1:0] r_ram [RAM_DEPTH];
    logic [DATA_W-1:0] r_ram_rdata;

    logic [3:0]        r_sw_meta;
    logic [3:0]        r_sw_sync;
    logic [3:0]        r_led;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_s1_valid;
    logic              r_s1_we;
    logic              r_s1_io;
    logic [3:0]        r_s1_off;
    logic [CNT_W-1:0]  r_s1_cnt;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_dout;

    logic              w_io_hit;
    logic              w_accept;
    logic              w_ram_we;
    logic              w_led_we;
    logic              w_cnt_we;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] w_rd_data;

    assign w_io_hit = (I_ADDR[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    // A request seen while reset is held must not commit anything, RAM included.
    assign w_accept = I_REQ & ~I_RESET;
    assign w_ram_we = w_accept & I_WE & ~w_io_hit;
    assign w_led_we = w_accept & I_WE & w_io_hit & (I_ADDR[3:0] == OFF_LED);
    assign w_cnt_we = w_accept & I_WE & w_io_hit & (I_ADDR[3:0] == OFF_CNT);

    assign w_cnt_next = w_cnt_we ? I_DIN[CNT_W-1:0] : r_cnt + 16'd1;

    // RAM is not reset; the read port is addressed straight from the request so
    // a write at one edge is visible to a read sampled at the next edge.
    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_ram[I_ADDR] <= I_DIN;
        end
        r_ram_rdata <= r_ram[I_ADDR];
    end

    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_sw_meta <= 4'd0;
            r_sw_sync <= 4'd0;
            r_led     <= 4'd0;
            r_cnt     <= '0;
        end else begin
            r_sw_meta <= I_SW;
            r_sw_sync <= r_sw_meta;
            r_cnt     <= w_cnt_next;
            if (w_led_we) begin
                r_led <= I_DIN[3:0];
            end
        end
    end

    // Counter reads report the value the counter takes at the sampling edge.
    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_io    <= 1'b0;
            r_s1_off   <= 4'd0;
            r_s1_cnt   <= '0;
        end else begin
            r_s1_valid <= I_REQ;
            r_s1_we    <= I_WE;
            r_s1_io    <= w_io_hit;
            r_s1_off   <= I_ADDR[3:0];
            r_s1_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (r_s1_io) begin
            case (r_s1_off)
                OFF_LED: w_rd_data = DATA_W'(r_led);
                OFF_SW:  w_rd_data = DATA_W'(r_sw_sync);
                OFF_CNT: w_rd_data = DATA_W'(r_s1_cnt);
                default: w_rd_data = '0;
            endcase
        end else begin
            w_rd_data = r_ram_rdata;
        end
    end

    // Write responses pulse O_VALID but leave O_DOUT holding the last read.
    always_ff @(posedge CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_s2_valid <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid && !r_s1_we) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign O_DOUT  = r_dout;
    assign O_VALID = r_s2_valid;
    assign O_LED   = r_led;

endmodule
